// File: rtl/riscv_muldiv_pkg.sv
// rtl/riscv_muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package riscv_muldiv_pkg;

   localparam int XLEN = 32;
   localparam logic [6:0] MULDIV_FUNC7 = 7'b0000001;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   function automatic logic is_divide(muldiv_op_t op);
      return op[2];
   endfunction

   function automatic logic is_remainder(muldiv_op_t op);
      return op[2] & op[1];
   endfunction

   function automatic logic a_is_signed(muldiv_op_t op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic b_is_signed(muldiv_op_t op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_sign_conditioner.sv
// rtl/muldiv_sign_conditioner.sv - sign extraction, magnitude and conditional negate
module muldiv_sign_conditioner #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         is_signed,
   input  logic         negate,
   output logic         sign,
   output logic [W-1:0] magnitude
);

   // On entry negate is 0 and this yields |value|; on exit is_signed is 0 and negate applies the result sign.
   assign sign      = is_signed & value[W-1];
   assign magnitude = (sign | negate) ? (~value + 1'b1) : value;

endmodule

// File: rtl/execute_muldiv_unit.sv
// rtl/execute_muldiv_unit.sv - iterative RV32M multiply/divide engine with pipeline stall
module execute_muldiv_unit #(
   parameter int XLEN       = riscv_muldiv_pkg::XLEN,
   parameter int ITERATIONS = XLEN
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] operandA,
   input  logic [XLEN-1:0] operandB,
   input  logic [4:0]      rdIn,
   output logic [XLEN-1:0] result,
   output logic            resultValid,
   output logic [4:0]      rdOut,
   output logic            busy,
   output logic            stallPipeline
);
   import riscv_muldiv_pkg::*;

   localparam int CW = $clog2(ITERATIONS) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(ITERATIONS - 1);

   muldiv_state_t     state_q;
   muldiv_op_t        op_q;
   logic [CW-1:0]     counter_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   b_q;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_q;
   logic              neg_q;
   logic              valid_q;

   muldiv_op_t      op_in;
   logic            sign_a, sign_b, neg_d;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_by_zero, div_overflow, special_d;
   logic [XLEN-1:0] special_result_d;

   assign op_in = muldiv_op_t'(func3);

   muldiv_sign_conditioner #(.W(XLEN)) u_cond_a (
      .value     (operandA),
      .is_signed (a_is_signed(op_in)),
      .negate    (1'b0),
      .sign      (sign_a),
      .magnitude (mag_a)
   );

   muldiv_sign_conditioner #(.W(XLEN)) u_cond_b (
      .value     (operandB),
      .is_signed (b_is_signed(op_in)),
      .negate    (1'b0),
      .sign      (sign_b),
      .magnitude (mag_b)
   );

   always_comb begin
      neg_d        = is_remainder(op_in) ? sign_a : (sign_a ^ sign_b);
      div_by_zero  = (operandB == '0);
      div_overflow = (op_in == OP_DIV || op_in == OP_REM) &&
                     (operandA == {1'b1, {(XLEN-1){1'b0}}}) && (operandB == '1);
      special_d    = is_divide(op_in) && (div_by_zero || div_overflow);
      if (div_by_zero)
         special_result_d = is_remainder(op_in) ? operandA : '1;
      else
         special_result_d = is_remainder(op_in) ? '0 : operandA;
   end

   // acc_q holds {partial product high, multiplier} for multiply and {remainder, quotient} for divide.
   logic [XLEN:0]     add_sum, shifted, trial;
   logic [2*XLEN-1:0] acc_step;

   always_comb begin
      add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      shifted = acc_q[2*XLEN-1:XLEN-1];
      trial   = shifted - {1'b0, b_q};
      if (!is_divide(op_q))
         acc_step = {add_sum, acc_q[XLEN-1:1]};
      else if (!trial[XLEN])
         acc_step = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         acc_step = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   logic [2*XLEN-1:0] exit_in, exit_out;
   logic              unused_exit_sign;
   logic [XLEN-1:0]   result_d;

   always_comb begin
      if (!is_divide(op_q))
         exit_in = acc_step;
      else if (is_remainder(op_q))
         exit_in = {{XLEN{1'b0}}, acc_step[2*XLEN-1:XLEN]};
      else
         exit_in = {{XLEN{1'b0}}, acc_step[XLEN-1:0]};
   end

   muldiv_sign_conditioner #(.W(2*XLEN)) u_cond_result (
      .value     (exit_in),
      .is_signed (1'b0),
      .negate    (neg_q),
      .sign      (unused_exit_sign),
      .magnitude (exit_out)
   );

   assign result_d = (op_q == OP_MUL || is_divide(op_q)) ? exit_out[XLEN-1:0]
                                                        : exit_out[2*XLEN-1:XLEN];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= OP_MUL;
         counter_q <= '0;
         acc_q     <= '0;
         b_q       <= '0;
         result_q  <= '0;
         rd_q      <= '0;
         neg_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else if (flush) begin
         state_q   <= IDLE;
         counter_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q      <= op_in;
                  rd_q      <= rdIn;
                  acc_q     <= {{XLEN{1'b0}}, mag_a};
                  b_q       <= mag_b;
                  neg_q     <= neg_d;
                  counter_q <= '0;
                  if (special_d) begin
                     state_q  <= DONE;
                     valid_q  <= 1'b1;
                     result_q <= special_result_d;
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               acc_q     <= acc_step;
               counter_q <= counter_q + 1'b1;
               if (counter_q == LAST_STEP) begin
                  state_q  <= DONE;
                  valid_q  <= 1'b1;
                  result_q <= result_d;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result        = result_q;
   assign rdOut         = rd_q;
   assign resultValid   = valid_q & ~flush;
   assign busy          = (state_q != IDLE);
   assign stallPipeline = ((state_q == IDLE) & start & ~flush) | (state_q == BUSY);

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb/tb_execute_muldiv_unit.sv - directed self-checking bench for execute_muldiv_unit
module tb_execute_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset, flush, start;
   logic [2:0]  func3;
   logic [31:0] operandA, operandB;
   logic [4:0]  rdIn;
   logic [31:0] result;
   logic        resultValid;
   logic [4:0]  rdOut;
   logic        busy, stallPipeline;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   execute_muldiv_unit dut (
      .clock         (clock),
      .reset         (reset),
      .flush         (flush),
      .start         (start),
      .func3         (func3),
      .operandA      (operandA),
      .operandB      (operandB),
      .rdIn          (rdIn),
      .result        (result),
      .resultValid   (resultValid),
      .rdOut         (rdOut),
      .busy          (busy),
      .stallPipeline (stallPipeline)
   );

   // Holds start like the decode-to-execute register would, until the DONE cycle is seen.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output int stall_hi, output logic stall_done);
      @(negedge clock);
      func3 = f; operandA = a; operandB = b; rdIn = rd; start = 1'b1;
      lat = 0; stall_hi = 0; res = 'x; rdo = 'x; stall_done = 1'bx;
      #1;
      if (stallPipeline) stall_hi++;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clock);
         if (resultValid) begin
            lat = n; res = result; rdo = rdOut; stall_done = stallPipeline;
            break;
         end
         if (stallPipeline) stall_hi++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; start = 1'b0;
      func3 = '0; operandA = '0; operandB = '0; rdIn = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks += 5;
      if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
      if (resultValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resultValid); end
      if (rdOut !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", rdOut); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if (stallPipeline !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stallPipeline); end
   endtask

   task automatic test_mul_latency();
      logic [31:0] res; logic [4:0] rdo; int lat, sh; logic sd;
      run_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd9, res, rdo, lat, sh, sd);
      checks += 5;
      if (res !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
      if (lat !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
      if (sh !== 33) begin errors++; $display("FAIL mul_stall_cycles got=%0d exp=33", sh); end
      if (sd !== 1'b0) begin errors++; $display("FAIL mul_stall_in_done got=%b exp=0", sd); end
      if (rdo !== 5'd9) begin errors++; $display("FAIL mul_rd got=%0d exp=9", rdo); end
   endtask

   task automatic test_mul_high();
      logic [2:0]  f [3] = '{3'b011, 3'b001, 3'b010};
      logic [31:0] a [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] b [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
      logic [31:0] e [3] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
      logic [31:0] res; logic [4:0] rdo; int lat, sh; logic sd;
      for (int i = 0; i < 3; i++) begin
         run_op(f[i], a[i], b[i], 5'(i + 1), res, rdo, lat, sh, sd);
         checks++;
         if (res !== e[i]) begin errors++; $display("FAIL mulh_%0d got=%h exp=%h", i, res, e[i]); end
      end
   endtask

   task automatic test_divide();
      logic [2:0]  f [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] a [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
      logic [31:0] b [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] e [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
      logic [31:0] res; logic [4:0] rdo; int lat, sh; logic sd;
      for (int i = 0; i < 4; i++) begin
         run_op(f[i], a[i], b[i], 5'(20 + i), res, rdo, lat, sh, sd);
         checks += 2;
         if (res !== e[i]) begin errors++; $display("FAIL div_%0d got=%h exp=%h", i, res, e[i]); end
         if (rdo !== 5'(20 + i)) begin errors++; $display("FAIL div_rd_%0d got=%0d exp=%0d", i, rdo, 20 + i); end
      end
   endtask

   task automatic test_special();
      logic [2:0]  f [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
      logic [31:0] a [4] = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
      logic [31:0] b [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] e [4] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
      logic [31:0] res; logic [4:0] rdo; int lat, sh; logic sd;
      for (int i = 0; i < 4; i++) begin
         run_op(f[i], a[i], b[i], 5'd17, res, rdo, lat, sh, sd);
         checks += 4;
         if (res !== e[i]) begin errors++; $display("FAIL special_%0d got=%h exp=%h", i, res, e[i]); end
         if (lat !== 1) begin errors++; $display("FAIL special_lat_%0d got=%0d exp=1", i, lat); end
         if (sh !== 1) begin errors++; $display("FAIL special_stall_%0d got=%0d exp=1", i, sh); end
         if (sd !== 1'b0) begin errors++; $display("FAIL special_stall_done_%0d got=%b exp=0", i, sd); end
      end
   endtask

   task automatic test_flush();
      int seen = 0;
      @(negedge clock);
      func3 = 3'b100; operandA = 32'd1000; operandB = 32'd3; rdIn = 5'd5; start = 1'b1;
      repeat (10) @(negedge clock);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0; start = 1'b0;
      #1;
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
      if (stallPipeline !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stallPipeline); end
      repeat (40) begin
         @(negedge clock);
         if (resultValid) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL flush_no_valid got=%0d exp=0", seen); end
      flush = 1'b1; start = 1'b1; func3 = 3'b000;
      #1;
      checks++;
      if (stallPipeline !== 1'b0) begin errors++; $display("FAIL flush_start_stall got=%b exp=0", stallPipeline); end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
      flush = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset_mid_busy();
      logic [31:0] res; logic [4:0] rdo; int lat, sh; logic sd;
      run_op(3'b111, 32'd100, 32'd7, 5'd12, res, rdo, lat, sh, sd);
      @(negedge clock);
      func3 = 3'b000; operandA = 32'd5; operandB = 32'd6; rdIn = 5'd30; start = 1'b1;
      repeat (6) @(negedge clock);
      reset = 1'b1; start = 1'b0;
      @(negedge clock);
      checks += 5;
      if (result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got=%h exp=0", result); end
      if (rdOut !== 5'd0) begin errors++; $display("FAIL rst_mid_rd got=%0d exp=0", rdOut); end
      if (resultValid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", resultValid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      if (stallPipeline !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%b exp=0", stallPipeline); end
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] res; logic [4:0] rdo; int lat, sh; logic sd;
      int lat2 = 0;
      run_op(3'b000, 32'd6, 32'd7, 5'd3, res, rdo, lat, sh, sd);
      checks += 2;
      if (res !== 32'd42) begin errors++; $display("FAIL b2b_mul got=%0d exp=42", res); end
      if (rdo !== 5'd3) begin errors++; $display("FAIL b2b_mul_rd got=%0d exp=3", rdo); end
      func3 = 3'b101; operandA = 32'd1000; operandB = 32'd10; rdIn = 5'd4; start = 1'b1;
      #1;
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_done_busy got=%b exp=1", busy); end
      if (stallPipeline !== 1'b0) begin errors++; $display("FAIL b2b_done_stall got=%b exp=0", stallPipeline); end
      for (int n = 1; n <= 100; n++) begin
         @(negedge clock);
         if (n == 1) begin
            checks += 2;
            if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
            if (stallPipeline !== 1'b1) begin errors++; $display("FAIL b2b_idle_stall got=%b exp=1", stallPipeline); end
         end
         if (resultValid) begin
            lat2 = n; res = result; rdo = rdOut;
            break;
         end
      end
      start = 1'b0;
      checks += 3;
      if (lat2 !== 34) begin errors++; $display("FAIL b2b_divu_lat got=%0d exp=34", lat2); end
      if (res !== 32'd100) begin errors++; $display("FAIL b2b_divu got=%0d exp=100", res); end
      if (rdo !== 5'd4) begin errors++; $display("FAIL b2b_divu_rd got=%0d exp=4", rdo); end
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_mul_latency();
      test_mul_high();
      test_divide();
      test_special();
      test_flush();
      test_reset_mid_busy();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
